// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache view, master = datapath/memory-controller view.
interface icache_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache of one-word lines, with saturating hit/miss counters.
// Hit: 0 cycles (combinational). Miss: 2 cycles plus one per memory wait cycle.
// Backpressure: the fetch side stalls (ihit=0) while FETCH waits on iwait from memory.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    icache_if.slave     bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX = $clog2(SETS);
    localparam int TW  = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state, next_state;
    logic [SETS-1:0]   valid;
    logic [TW-1:0]     tagq  [SETS];
    logic [31:0]       dataq [SETS];
    logic [31:0]       missaddr;

    logic [IDX-1:0]    index;
    logic [TW-1:0]     tag;
    logic [IDX-1:0]    fill_index;
    logic [TW-1:0]     fill_tag;
    logic              hit;
    logic              miss;
    logic              fill;
    logic              unused_addr_bits;

    assign index      = bus.imemaddr[IDX+1:2];
    assign tag        = bus.imemaddr[31:IDX+2];
    assign fill_index = missaddr[IDX+1:2];
    assign fill_tag   = missaddr[31:IDX+2];
    assign unused_addr_bits = ^{bus.imemaddr[1:0], missaddr[1:0]};

    assign hit  = bus.imemREN && valid[index] && (tagq[index] == tag) && (state == IDLE);
    assign miss = bus.imemREN && !hit && (state == IDLE);
    assign fill = (state == FETCH) && !bus.iwait;

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? dataq[index] : 32'd0;
    // Memory-side request comes straight from registered state, never from the fetch address.
    assign bus.iREN     = (state == FETCH);
    assign bus.iaddr    = (state == FETCH) ? missaddr : 32'd0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss)          next_state = FETCH;
            FETCH:   if (!bus.iwait)    next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid    <= '0;
            missaddr <= 32'd0;
        end else begin
            if (miss) begin
                missaddr <= {bus.imemaddr[31:2], 2'b00};
            end
            if (fill) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tagq[fill_index]  <= fill_tag;
            dataq[fill_index] <= bus.iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized and directed checks of icache against a line-by-word-address reference model.
module tb_icache;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    icache_if bus();

    icache #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .bus      (bus.slave),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: each line remembers the full word address it holds.
    bit          m_fetch;
    logic [29:0] m_miss;
    int          wait_left;
    int          wait_cfg;
    bit          lv [SETS];
    logic [29:0] la [SETS];
    logic [31:0] ld [SETS];
    logic [31:0] m_hits, m_misses;
    logic [31:0] mem [logic [29:0]];
    logic        s_hit;
    logic [31:0] s_load;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic model_reset();
        m_fetch   = 0;
        m_miss    = '0;
        wait_left = 0;
        m_hits    = 0;
        m_misses  = 0;
        for (int i = 0; i < SETS; i++) lv[i] = 0;
    endtask

    task automatic drive_mem();
        bus.iwait = (m_fetch && wait_left > 0);
        bus.iload = (m_fetch && !bus.iwait) ? mem_rd(m_miss) : $urandom;
    endtask

    task automatic cycle();
        int          idx;
        bit          eh;
        logic [29:0] wa;
        drive_mem();
        @(negedge CLK);
        wa  = bus.imemaddr[31:2];
        idx = int'(wa % SETS);
        eh  = !m_fetch && bus.imemREN && lv[idx] && (la[idx] == wa);
        s_hit  = bus.ihit;
        s_load = bus.imemload;
        chk("ihit",     {31'd0, bus.ihit}, {31'd0, eh});
        chk("imemload", bus.imemload, eh ? ld[idx] : 32'd0);
        chk("iREN",     {31'd0, bus.iREN}, {31'd0, m_fetch});
        chk("iaddr",    bus.iaddr, m_fetch ? {m_miss, 2'b00} : 32'd0);
        chk("hit_cnt",  hit_cnt,  m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
        if (eh) m_hits++;
        if (!m_fetch && bus.imemREN && !eh) begin
            m_fetch   = 1;
            m_miss    = wa;
            m_misses++;
            wait_left = wait_cfg;
        end else if (m_fetch) begin
            if (bus.iwait) begin
                wait_left--;
            end else begin
                idx     = int'(m_miss % SETS);
                lv[idx] = 1;
                la[idx] = m_miss;
                ld[idx] = mem_rd(m_miss);
                m_fetch = 0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        chk("rst iREN",     {31'd0, bus.iREN}, 32'd0);
        chk("rst ihit",     {31'd0, bus.ihit}, 32'd0);
        chk("rst imemload", bus.imemload, 32'd0);
        chk("rst iaddr",    bus.iaddr, 32'd0);
        chk("rst hit_cnt",  hit_cnt, 32'd0);
        chk("rst miss_cnt", miss_cnt, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        logic [31:0] m0, h0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'd0;
        bus.iwait    = 1'b0;
        bus.iload    = 32'd0;
        wait_cfg     = 0;
        model_reset();
        #2;
        do_reset();

        // Reset then first fetch, zero wait states.
        mem[30'h0]   = 32'h2002_0005;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0;
        cycle();
        chk("t1 cyc0 ihit", {31'd0, s_hit}, 32'd0);
        cycle();
        cycle();
        chk("t1 cyc2 ihit", {31'd0, s_hit}, 32'd1);
        chk("t1 cyc2 load", s_load, 32'h2002_0005);
        chk("t1 miss_cnt",  miss_cnt, 32'd1);

        // Five wait states: miss, six iREN cycles, then the hit.
        wait_cfg     = 5;
        bus.imemaddr = 32'h40;
        for (int i = 0; i < 7; i++) cycle();
        chk("t2 pre-hit", {31'd0, s_hit}, 32'd0);
        cycle();
        chk("t2 hit",  {31'd0, s_hit}, 32'd1);
        chk("t2 load", s_load, mem[30'h10]);

        // Conflict eviction on index 1, with memory changed before the reload.
        wait_cfg     = 0;
        m0           = miss_cnt;
        mem[30'h1]   = 32'hCAFE_0001;
        bus.imemaddr = 32'h04;
        for (int i = 0; i < 3; i++) cycle();
        bus.imemaddr = 32'h44;
        for (int i = 0; i < 3; i++) cycle();
        mem[30'h1]   = 32'hCAFE_0002;
        bus.imemaddr = 32'h04;
        for (int i = 0; i < 3; i++) cycle();
        chk("t3 reload",   s_load, 32'hCAFE_0002);
        chk("t3 misses",   miss_cnt - m0, 32'd3);

        // Fetch address changes while the fill is waiting.
        wait_cfg     = 3;
        m0           = miss_cnt;
        bus.imemaddr = 32'h08;
        cycle();
        bus.imemaddr = 32'h0C;
        cycle();
        chk("t4 iaddr held", bus.iaddr, 32'h08);
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 6; i++) cycle();
        chk("t4 misses", miss_cnt - m0, 32'd2);
        chk("t4 line2 valid", {31'd0, lv[2]}, 32'd1);

        // No request at a cached address.
        wait_cfg     = 0;
        bus.imemaddr = 32'h40;
        bus.imemREN  = 1'b0;
        m0 = miss_cnt;
        h0 = hit_cnt;
        for (int i = 0; i < 10; i++) cycle();
        chk("t5 hit_cnt",  hit_cnt,  h0);
        chk("t5 miss_cnt", miss_cnt, m0);

        // Reset while a fill is outstanding.
        wait_cfg     = 4;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h80;
        cycle();
        cycle();
        chk("t6 iREN before rst", {31'd0, bus.iREN}, 32'd1);
        do_reset();
        wait_cfg     = 0;
        bus.imemaddr = 32'h40;
        cycle();
        chk("t6 refetch misses", {31'd0, s_hit}, 32'd0);
        for (int i = 0; i < 2; i++) cycle();

        // Random traffic over a small pool of tags to provoke hits and aliasing.
        for (int i = 0; i < 2000; i++) begin
            bus.imemREN  = ($urandom_range(0, 3) != 0);
            bus.imemaddr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS - 1) << 2)
                         | $urandom_range(0, 3);
            wait_cfg     = $urandom_range(0, 3);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache sitting directly downstream of the pipelined datapath's fetch port and upstream of the memory controller. It answers instruction fetches (`imemREN`/`imemaddr`) with `ihit`/`imemload` in the same cycle on a hit. On a miss it issues a single-word read to the memory controller, fills the line, and then hits on the retried fetch. It also keeps saturating hit and miss counters for performance reporting.

## Interface
Parameters:
- `SETS`, 16: number of one-word lines; a power of two, at least 2. `IDX = log2(SETS)`.

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `imemREN` in 1: datapath fetch request.
- `imemaddr` in 32: fetch byte address. Bits [1:0] are ignored.
- `ihit` out 1: fetch satisfied this cycle.
- `imemload` out 32: instruction word. Valid when `ihit`=1, otherwise 0.
- `iREN` out 1: read request to the memory controller.
- `iaddr` out 32: word-aligned read address to the memory controller.
- `iwait` in 1: 1 while the memory controller has not yet returned data.
- `iload` in 32: read data. Valid in the cycle where `iREN`=1 and `iwait`=0.
- `hit_cnt` out 32: saturating count of cycles with `ihit`=1.
- `miss_cnt` out 32: saturating count of misses, i.e. IDLE→FETCH transitions.

## Operation
- **Address split:**
  - index = `imemaddr[IDX+1:2]`
  - tag = `imemaddr[31:IDX+2]`
  - Each line holds a valid bit, a tag of 30−IDX bits, and a 32-bit data word.
- **Hit:** `ihit` = `imemREN` & `valid[index]` & (`tagq[index]` == tag) & (state == IDLE). This is combinational.
- **State IDLE:**
  - `iREN`=0 and `iaddr`=0.
  - If `imemREN`=1 and there is no hit: latch `{imemaddr[31:2],2'b00}` into `missaddr`, increment `miss_cnt`, and go to FETCH.
- **State FETCH:**
  - `iREN`=1 and `iaddr`=`missaddr`. Both are driven from registers only.
  - `ihit`=0 for the whole state, including when the requested address changes.
  - On a rising edge where `iwait`=0: write `iload`, `valid`=1, and the `missaddr` tag into line `missaddr` index, then go to IDLE.
  - While `iwait`=1: remain in FETCH.
- **Ignored inputs during FETCH:** `imemREN` falling, or `imemaddr` changing, does not abort the fetch. The fill completes to `missaddr`.
- **After the fill:** a new mismatch in IDLE simply causes another miss.
- **Replacement:** a fill unconditionally overwrites the indexed line; there is no write-back.
- **Counters:** saturate at 32'hFFFF_FFFF and hold there.

## Timing
- **Reset** (asynchronous, takes effect immediately, including mid-FETCH):
  - state=IDLE; all `valid`=0; `missaddr`=0; `hit_cnt`=`miss_cnt`=0.
  - Outputs: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
  - Tag and data arrays need not be reset.
- **Hit latency:** 0 cycles (combinational from `imemaddr`).
- **Miss timeline:**
  - Cycle 0: miss detected; `iREN` still 0.
  - Cycle 1: `iREN`=1.
  - The line is written on the first edge with `iwait`=0.
  - `ihit`=1 in the following cycle if the address is unchanged.
- **Miss penalty:** with a memory that has zero wait states (`iwait`=0 as soon as `iREN` rises), a miss costs exactly 2 cycles with `ihit`=0. Each additional wait cycle adds one.
- **`iREN`:** never asserted in the same cycle the miss is detected. It deasserts the cycle after the fill edge.
- **Index aliasing:** two addresses that share an index but differ in tag each miss in turn. There is no stale hit.
- **Counting:** `hit_cnt` increments on every edge where `ihit`=1, so a stalled pipeline re-presenting a hit counts every cycle. `miss_cnt` increments only on the IDLE→FETCH edge.

## Test plan
- **Reset then first fetch:** release `nRST`, `imemREN`=1, `imemaddr`=0x0, `iwait`=0 on the first `iREN` cycle, `iload`=0x2002_0005.
  - Cycle 0: `ihit`=0. Cycle 1: `iREN`=1, `iaddr`=0x0. Cycle 2: `ihit`=1, `imemload`=0x2002_0005.
  - `miss_cnt`=1, `hit_cnt` increments from cycle 2.
- **Wait states:** miss at 0x40 with `iwait`=1 held for 5 cycles.
  - `iREN`=1 and `iaddr`=0x40 for 6 cycles, with `ihit`=0 throughout.
  - Hit with the returned word one cycle after `iwait` falls.
- **Conflict eviction:** fill 0x04, then 0x44 (same index with `SETS`=16), then return to 0x04.
  - All three accesses miss; `miss_cnt`=3.
  - The final fetch of 0x04 returns the word reloaded from memory.
- **Address change mid-fill:** miss at 0x08; change `imemaddr` to 0x0C while `iwait`=1.
  - `iaddr` stays 0x08 and line 2 fills.
  - Then a miss for 0x0C starts; `miss_cnt`=2.
- **Reset mid-FETCH:** assert `nRST`=0 while `iREN`=1.
  - `iREN`=0 immediately.
  - After release, the previously filled lines miss again (valid cleared) and counters read 0.
- **No request:** `imemREN`=0 for 10 cycles at a cached address.
  - `ihit`=0, `iREN`=0, and the counters do not change.
